usr_burst_shift_reg: RTL and testbench
======================================

// Module: usr_burst_shift_reg
// PURPOSE
//   Parametrised universal shift register, next generation of the 4-bit universal register.
//   Adds multi-bit STEP shifts, rotate, arithmetic and clear modes, and a serial-out capture.
//   Adds a counted burst engine: one start command performs COUNT shifts, then pulses done.
//   Sits between serial links and parallel datapaths as a serializer/deserializer/barrel stage.
// PARAMETERS
//   N      8  register width in bits (N >= 2)
//   STEP   1  bits moved per shift/rotate operation (1 <= STEP <= N-1)
//   CNT_W  4  width of the burst count input
// PORTS
//   clk      in   1       rising-edge clock, single clock domain
//   reset    in   1       asynchronous, active-high reset
//   MSB_in   in   STEP    fill bits for right shift (mode 001)
//   LSB_in   in   STEP    fill bits for left shift (mode 010)
//   I        in   N       parallel load data (mode 011)
//   s        in   3       mode select (see BEHAVIOUR)
//   en       in   1       single-operation strobe (IDLE only)
//   start    in   1       burst start strobe (IDLE only; priority over en)
//   count    in   CNT_W   burst length, sampled with start
//   abort    in   1       terminate a burst in progress
//   Q        out  N       register contents
//   so       out  STEP    bits shifted/rotated out by the last shift operation
//   busy     out  1       burst in progress
//   done     out  1       one-cycle burst-complete pulse
//   parity   out  1       even parity of Q (only with USR_PARITY_EN)
// BEHAVIOUR
//   Reset (async, any state): Q=0, so=0, busy=0, done=0, parity=0, FSM=IDLE, remaining=0.
//   Modes s: 000 hold; 001 SRL, top STEP bits <= MSB_in; 010 SLL, low STEP bits <= LSB_in.
//     011 load I; 100 rotate right STEP; 101 rotate left STEP.
//     110 arithmetic right STEP (Q[N-1] replicated); 111 clear to 0.
//   so: right shifts/rotates/ASR capture old Q[STEP-1:0]; left capture old Q[N-1:N-STEP].
//     hold, load and clear leave so unchanged.
//   FSM IDLE/BUSY. done is registered, high for exactly one cycle, and never high with busy.
//   IDLE, en=1, start=0: apply s once at this edge; no done; stay IDLE.
//   IDLE, start=1 (en ignored): latch s as burst mode; call the start edge t0.
//     count=0: no operation; done=1 after t0.
//     s in {000,011,111}: op applied once at t0; done=1 after t0.
//     shift mode, count=K>=1: shifts on edges t0..t0+K-1 (one per cycle).
//       busy=1 after t0 while remaining>0; at edge t0+K-1 busy<=0, done<=1, FSM=IDLE.
//       K=1: busy never asserts; done after t0.
//   BUSY: s, en, start, count, I, MSB_in, LSB_in changes do not alter the latched mode.
//     MSB_in and LSB_in are still sampled live every shift.
//   BUSY, abort=1: no shift that edge; FSM=IDLE, busy=0, done stays 0; Q and so hold.
//   abort in IDLE: no effect. abort and start together in IDLE: start wins.
//   Q changes only on an accepted op; all outputs are registered.
// CONFIGURATION
//   USR_PARITY_EN defined: parity port present, registered, updated with Q (=^next Q).
//   USR_PARITY_EN undefined: parity port and logic absent; all else identical.
// STRUCTURE
//   Package usr_pkg: mode localparams (USR_HOLD..USR_CLR, 3-bit), FSM state encoding.
//   Sub-module usr_shift_datapath: combinational, (Q, s, MSB_in, LSB_in, I) -> (q_next, so_next).
//   Top holds FSM, remaining counter, output registers.
// TESTING (N=8, STEP=1 unless noted)
//   Reset during activity -> Q=00, so=0, busy=0, done=0 immediately, without waiting for clk.
//   en, s=011, I=A5 -> Q=A5. Then en, s=100 -> Q=D2, so=1. Then en, s=101 -> Q=A5, so=1.
//   Q=90: en, s=110 -> C8. Q=81: en, s=010, LSB_in=0 -> 02, so=1. en, s=111 -> 00.
//   Q=00: start, s=001, count=3, MSB_in=1 -> Q 80,C0,E0.
//     busy 2 cycles, then done 1 cycle; en pulses during busy are ignored.
//   Q=01: start, s=010, count=5, LSB_in=0, abort after 2 shifts -> Q=04, busy=0, no done.
//     Reset mid-burst -> IDLE, Q=00.
//   STEP=4, USR_PARITY_EN: Q=3C, en, s=100 -> Q=C3, so=C, parity=0.
//     Load 07 -> parity=1. count=0 start -> done only.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared mode encodings and FSM state type for the burst universal shift register.
package usr_pkg;

    localparam logic [2:0] USR_HOLD = 3'b000;
    localparam logic [2:0] USR_SRL  = 3'b001;
    localparam logic [2:0] USR_SLL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROR  = 3'b100;
    localparam logic [2:0] USR_ROL  = 3'b101;
    localparam logic [2:0] USR_ASR  = 3'b110;
    localparam logic [2:0] USR_CLR  = 3'b111;

    typedef enum logic {
        StIdle,
        StBusy
    } usr_state_e;

    // Modes that complete in one operation even when issued as a burst.
    function automatic logic usr_is_single_op(input logic [2:0] mode);
        return (mode == USR_HOLD) || (mode == USR_LOAD) || (mode == USR_CLR);
    endfunction

endpackage

// File: rtl/usr_shift_datapath.sv
// Combinational next-value logic: current register, mode and fill inputs -> next Q and
// shifted-out bits, with a flag telling whether the mode moves bits out at all.
module usr_shift_datapath
    import usr_pkg::*;
#(
    parameter int unsigned N    = 8,
    parameter int unsigned STEP = 1
) (
    input  logic [N-1:0]    q_i,
    input  logic [2:0]      s_i,
    input  logic [STEP-1:0] msb_in_i,
    input  logic [STEP-1:0] lsb_in_i,
    input  logic [N-1:0]    data_i,
    output logic [N-1:0]    q_next_o,
    output logic [STEP-1:0] so_next_o,
    output logic            so_upd_o
);

    always_comb begin
        q_next_o  = q_i;
        so_next_o = q_i[STEP-1:0];
        so_upd_o  = 1'b0;
        unique case (s_i)
            USR_HOLD: q_next_o = q_i;
            USR_SRL: begin
                q_next_o = {msb_in_i, q_i[N-1:STEP]};
                so_upd_o = 1'b1;
            end
            USR_SLL: begin
                q_next_o  = {q_i[N-STEP-1:0], lsb_in_i};
                so_next_o = q_i[N-1:N-STEP];
                so_upd_o  = 1'b1;
            end
            USR_LOAD: q_next_o = data_i;
            USR_ROR: begin
                q_next_o = {q_i[STEP-1:0], q_i[N-1:STEP]};
                so_upd_o = 1'b1;
            end
            USR_ROL: begin
                q_next_o  = {q_i[N-STEP-1:0], q_i[N-1:N-STEP]};
                so_next_o = q_i[N-1:N-STEP];
                so_upd_o  = 1'b1;
            end
            USR_ASR: begin
                q_next_o = $signed(q_i) >>> STEP;
                so_upd_o = 1'b1;
            end
            USR_CLR: q_next_o = '0;
            default: q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/usr_burst_shift_reg.sv
// Universal shift register with single-op strobe and counted burst engine.
// Define USR_PARITY_EN to add a registered even-parity output tracking Q.
module usr_burst_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [STEP-1:0]  msb_in_i,
    input  logic [STEP-1:0]  lsb_in_i,
    input  logic [N-1:0]     data_i,
    input  logic [2:0]       s_i,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic             abort_i,
    output logic [N-1:0]     q_o,
    output logic [STEP-1:0]  so_o,
    output logic             busy_o,
    output logic             done_o
`ifdef USR_PARITY_EN
    ,
    output logic             parity_o
`endif
);

    usr_state_e       state_q;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] rem_q;
    logic [N-1:0]     q_q;
    logic [STEP-1:0]  so_q;
    logic             busy_q;
    logic             done_q;

    logic [2:0]       mode_sel;
    logic [N-1:0]     q_next;
    logic [STEP-1:0]  so_next;
    logic             so_upd;
    logic             op_fire;

    // While busy the latched burst mode drives the datapath, never the live select.
    always_comb begin
        mode_sel = (state_q == StBusy) ? mode_q : s_i;
        op_fire  = 1'b0;
        if (state_q == StBusy) begin
            op_fire = !abort_i;
        end else if (start_i) begin
            op_fire = (count_i != '0);
        end else begin
            op_fire = en_i;
        end
    end

    usr_shift_datapath #(
        .N    (N),
        .STEP (STEP)
    ) u_datapath (
        .q_i       (q_q),
        .s_i       (mode_sel),
        .msb_in_i  (msb_in_i),
        .lsb_in_i  (lsb_in_i),
        .data_i    (data_i),
        .q_next_o  (q_next),
        .so_next_o (so_next),
        .so_upd_o  (so_upd)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_q  <= '0;
            so_q <= '0;
        end else if (op_fire) begin
            q_q <= q_next;
            if (so_upd) begin
                so_q <= so_next;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            mode_q  <= USR_HOLD;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        mode_q <= s_i;
                        if (count_i == '0 || usr_is_single_op(s_i) ||
                            count_i == CNT_W'(1)) begin
                            done_q <= 1'b1;
                        end else begin
                            rem_q   <= count_i - CNT_W'(1);
                            busy_q  <= 1'b1;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    if (abort_i) begin
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (rem_q == CNT_W'(1)) begin
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        rem_q <= rem_q - CNT_W'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef USR_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            parity_q <= 1'b0;
        end else if (op_fire) begin
            parity_q <= ^q_next;
        end
    end

    assign parity_o = parity_q;
`endif

    assign q_o    = q_q;
    assign so_o   = so_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_usr_burst_shift_reg.sv
// Directed bench for usr_burst_shift_reg: an N=8/STEP=1 instance and an N=8/STEP=4 instance.
module tb_usr_burst_shift_reg;

    logic       clk;
    logic       rst;
    logic [0:0] msb, lsb;
    logic [7:0] data;
    logic [2:0] s;
    logic       en, start, abort;
    logic [3:0] count;
    logic [7:0] q;
    logic [0:0] so;
    logic       busy, done;

    logic [3:0] msb4, lsb4;
    logic [7:0] data4;
    logic [2:0] s4;
    logic       en4, start4, abort4;
    logic [3:0] count4;
    logic [7:0] q4;
    logic [3:0] so4;
    logic       busy4, done4;
`ifdef USR_PARITY_EN
    logic       par1, par4;
`endif

    int vectors = 0;
    int errors  = 0;

    usr_burst_shift_reg #(.N(8), .STEP(1), .CNT_W(4)) dut (
        .clk_i    (clk),
        .reset_i  (rst),
        .msb_in_i (msb),
        .lsb_in_i (lsb),
        .data_i   (data),
        .s_i      (s),
        .en_i     (en),
        .start_i  (start),
        .count_i  (count),
        .abort_i  (abort),
        .q_o      (q),
        .so_o     (so),
        .busy_o   (busy),
        .done_o   (done)
`ifdef USR_PARITY_EN
        ,
        .parity_o (par1)
`endif
    );

    usr_burst_shift_reg #(.N(8), .STEP(4), .CNT_W(4)) dut4 (
        .clk_i    (clk),
        .reset_i  (rst),
        .msb_in_i (msb4),
        .lsb_in_i (lsb4),
        .data_i   (data4),
        .s_i      (s4),
        .en_i     (en4),
        .start_i  (start4),
        .count_i  (count4),
        .abort_i  (abort4),
        .q_o      (q4),
        .so_o     (so4),
        .busy_o   (busy4),
        .done_o   (done4)
`ifdef USR_PARITY_EN
        ,
        .parity_o (par4)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One en-strobed operation on the STEP=1 instance.
    task automatic op1(input logic [2:0] mode, input logic [7:0] d, input logic l);
        s = mode; data = d; lsb = l; en = 1'b1;
        tick();
        en = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        msb = '0; lsb = '0; data = '0; s = '0; en = 0; start = 0; abort = 0; count = '0;
        msb4 = '0; lsb4 = '0; data4 = '0; s4 = '0; en4 = 0; start4 = 0; abort4 = 0;
        count4 = '0;
        #3;
        chk("rst_q", q, 8'h00);
        chk("rst_so", so, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        op1(3'b011, 8'hA5, 1'b0);
        chk("load_a5", q, 8'hA5);
        chk("load_no_done", done, 1'b0);
        op1(3'b100, 8'h00, 1'b0);
        chk("ror_q", q, 8'hD2);
        chk("ror_so", so, 1'b1);
        op1(3'b101, 8'h00, 1'b0);
        chk("rol_q", q, 8'hA5);
        chk("rol_so", so, 1'b1);
        op1(3'b011, 8'h90, 1'b0);
        op1(3'b110, 8'h00, 1'b0);
        chk("asr_q", q, 8'hC8);
        chk("asr_so", so, 1'b0);
        op1(3'b011, 8'h81, 1'b0);
        op1(3'b010, 8'h00, 1'b0);
        chk("sll_q", q, 8'h02);
        chk("sll_so", so, 1'b1);
        op1(3'b111, 8'h00, 1'b0);
        chk("clr_q", q, 8'h00);
        chk("clr_so_kept", so, 1'b1);

        // Burst SRL x3 with MSB_in=1; en/load attempts during busy must be ignored.
        s = 3'b001; count = 4'd3; msb = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; s = 3'b011; data = 8'hFF; en = 1'b1; count = 4'd9;
        chk("b1_q", q, 8'h80);
        chk("b1_busy", busy, 1'b1);
        chk("b1_done", done, 1'b0);
        tick();
        chk("b2_q", q, 8'hC0);
        chk("b2_busy", busy, 1'b1);
        chk("b2_done", done, 1'b0);
        tick();
        en = 1'b0; s = 3'b000;
        chk("b3_q", q, 8'hE0);
        chk("b3_busy", busy, 1'b0);
        chk("b3_done", done, 1'b1);
        tick();
        chk("b4_done_pulse", done, 1'b0);
        chk("b4_q", q, 8'hE0);

        // Burst SLL x5 aborted after two shifts.
        op1(3'b011, 8'h01, 1'b0);
        s = 3'b010; count = 4'd5; lsb = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("a1_q", q, 8'h02);
        tick();
        chk("a2_q", q, 8'h04);
        chk("a2_busy", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_q", q, 8'h04);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        tick();
        chk("abort_no_done", done, 1'b0);
        chk("abort_q_hold", q, 8'h04);

        // count=0: done only, Q untouched.
        s = 3'b001; count = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("c0_q", q, 8'h04);
        chk("c0_done", done, 1'b1);
        chk("c0_busy", busy, 1'b0);
        // count=1: one shift, busy never rises.
        s = 3'b010; count = 4'd1; lsb = 1'b1; start = 1'b1; en = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; en = 1'b0; abort = 1'b0;
        chk("c1_q", q, 8'h09);
        chk("c1_busy", busy, 1'b0);
        chk("c1_done", done, 1'b1);
        // Clear as a burst: single op then done.
        s = 3'b111; count = 4'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk("bclr_q", q, 8'h00);
        chk("bclr_busy", busy, 1'b0);
        chk("bclr_done", done, 1'b1);

        // Asynchronous reset mid-burst.
        op1(3'b011, 8'h01, 1'b0);
        s = 3'b101; count = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_busy", busy, 1'b1);
        chk("mid_q", q, 8'h04);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_q", q, 8'h00);
        chk("arst_so", so, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("post_rst_q", q, 8'h00);
        chk("post_rst_busy", busy, 1'b0);

        // STEP=4 instance.
        s4 = 3'b011; data4 = 8'h3C; en4 = 1'b1;
        tick();
        s4 = 3'b100;
        tick();
        en4 = 1'b0;
        chk("s4_ror_q", q4, 8'hC3);
        chk("s4_ror_so", so4, 4'hC);
`ifdef USR_PARITY_EN
        chk("s4_par_c3", par4, 1'b0);
`endif
        s4 = 3'b011; data4 = 8'h07; en4 = 1'b1;
        tick();
        en4 = 1'b0;
        chk("s4_load_07", q4, 8'h07);
`ifdef USR_PARITY_EN
        chk("s4_par_07", par4, 1'b1);
`endif
        s4 = 3'b010; lsb4 = 4'hA; count4 = 4'd0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("s4_c0_q", q4, 8'h07);
        chk("s4_c0_done", done4, 1'b1);
        s4 = 3'b010; lsb4 = 4'hA; count4 = 4'd2; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        chk("s4_sll1_q", q4, 8'h7A);
        chk("s4_sll1_so", so4, 4'h0);
        tick();
        chk("s4_sll2_q", q4, 8'hAA);
        chk("s4_sll2_so", so4, 4'h7);
        chk("s4_sll2_done", done4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
